nco_sample_reader: RTL and testbench

Read-side engine for the NCO sine table. It accepts 8-bit phase requests over a valid/ready handshake and reads the matching 32-bit signed sample from the two 128-word table banks. Bank 0 holds phases 0–127 and bank 1 holds 128–255; both are loaded through port 0. The block returns each sample rounded and saturated to OUT_W bits, in request order, through an output FIFO that absorbs SRAM read latency and downstream backpressure. It sits between the phase accumulator and the DAC/output stage.

---
 rtl/nco_sample_reader.sv | 133 +++++++++++++
 tb/tb_nco_sample_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sample_reader.sv
// nco_sample_reader: reads 32-bit sine samples from two table banks for
// 8-bit phase requests, rounds and saturates them to OUT_W bits, and returns
// them in request order through a small output FIFO.
module nco_sample_reader #(
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_phase,
    output logic             csb01,
    output logic             csb11,
    output logic [6:0]       addr1,
    input  logic [31:0]      dout01,
    input  logic [31:0]      dout11,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [OUT_W-1:0] smp_data,
    output logic [7:0]       smp_phase,
    output logic             busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RND   = 32'd1 << (31 - OUT_W);
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    logic             run_q;
    logic             inflight_q;
    logic             infl_bank_q;
    logic [7:0]       infl_phase_q;
    logic [OUT_W-1:0] mem_data  [FIFO_DEPTH];
    logic [7:0]       mem_phase [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             accept_c;
    logic             push_c;
    logic             pop_c;
    logic [31:0]      raw_c;
    logic [31:0]      sum_c;
    logic [OUT_W-1:0] sat_c;
    logic [OUT_W-1:0] head_data_c;
    logic [7:0]       head_phase_c;

    // Credit check: the pending capture always owns a FIFO slot.
    assign req_ready = run_q && enable &&
                       ((count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
    assign accept_c  = req_valid && req_ready;

    // Read-port drive for the accept cycle; one bank at most.
    always_comb begin
        csb01 = 1'b1;
        csb11 = 1'b1;
        addr1 = 7'd0;
        if (accept_c) begin
            csb01 = req_phase[7];
            csb11 = !req_phase[7];
            addr1 = req_phase[6:0];
        end
    end

    // Round half-up then clamp; only positive overflow is reachable.
    always_comb begin
        raw_c = infl_bank_q ? dout11 : dout01;
        sum_c = raw_c + 32'(RND);
        sat_c = (!raw_c[31] && sum_c[31]) ? SAT_MAX : sum_c[31 -: OUT_W];
    end

    // FIFO bookkeeping and next head; a push into an emptied FIFO bypasses.
    always_comb begin
        push_c   = inflight_q;
        pop_c    = smp_valid && smp_ready;
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        head_data_c  = mem_data[rd_ptr_d];
        head_phase_c = mem_phase[rd_ptr_d];
        if (push_c && (rd_ptr_d == wr_ptr_q)) begin
            head_data_c  = sat_c;
            head_phase_c = infl_phase_q;
        end
    end

    // Control state, in-flight slot and registered FIFO-head outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q        <= 1'b0;
            inflight_q   <= 1'b0;
            infl_bank_q  <= 1'b0;
            infl_phase_q <= 8'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            smp_valid    <= 1'b0;
            smp_data     <= '0;
            smp_phase    <= 8'd0;
            busy         <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= accept_c;
            if (accept_c) begin
                infl_bank_q  <= req_phase[7];
                infl_phase_q <= req_phase;
            end
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            smp_valid <= (count_d != '0);
            busy      <= accept_c || (count_d != '0);
            if (count_d != '0) begin
                smp_data  <= head_data_c;
                smp_phase <= head_phase_c;
            end
        end
    end

    // FIFO storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data[wr_ptr_q]  <= sat_c;
            mem_phase[wr_ptr_q] <= infl_phase_q;
        end
    end

endmodule

// File: tb/tb_nco_sample_reader.sv
// Bench for nco_sample_reader: sine-table SRAM model, queue scoreboard,
// directed vectors and randomized traffic.
module tb_nco_sample_reader;

    localparam int unsigned OUT_W = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_phase;
    logic             csb01;
    logic             csb11;
    logic [6:0]       addr1;
    logic [31:0]      dout01;
    logic [31:0]      dout11;
    logic             smp_valid;
    logic             smp_ready;
    logic [OUT_W-1:0] smp_data;
    logic [7:0]       smp_phase;
    logic             busy;

    nco_sample_reader #(.OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_phase(req_phase),
        .csb01(csb01), .csb11(csb11), .addr1(addr1),
        .dout01(dout01), .dout11(dout11),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_data(smp_data), .smp_phase(smp_phase), .busy(busy)
    );

    always #5 clk = ~clk;

    int tbl [256];

    // Two 128-word banks with one-cycle read latency.
    always @(posedge clk) begin
        if (!csb01) dout01 <= tbl[{1'b0, addr1}];
        if (!csb11) dout11 <= tbl[{1'b1, addr1}];
    end

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]       q [$];
    bit               run_m;
    bit               prev_stall;
    logic [OUT_W-1:0] prev_data;
    logic [7:0]       prev_phase;
    bit               last_acc;
    bit               last_pop;
    logic [7:0]       last_pop_phase;
    logic             last_csb01;
    logic             last_csb11;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference sample: floor((v + 2^(31-OUT_W)) / 2^(32-OUT_W)), clamped to max.
    function automatic logic [OUT_W-1:0] ref_sample(input logic [7:0] ph);
        longint v, s, r, mx;
        v  = longint'(tbl[ph]);
        s  = v + (longint'(1) << (31 - OUT_W));
        r  = s >>> (32 - OUT_W);
        mx = (longint'(1) << (OUT_W - 1)) - 1;
        if (r > mx) r = mx;
        return OUT_W'(r);
    endfunction

    // One clock cycle: check the pre-edge state against the model, update it, advance.
    task automatic cyc();
        bit exp_ready;
        logic [7:0] ph;
        #1;
        exp_ready = run_m && enable && (q.size() < DEPTH);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        if (prev_stall) begin
            chk("hold_valid", 32'(smp_valid), 32'd1);
            chk("hold_data", 32'(smp_data), 32'(prev_data));
            chk("hold_phase", 32'(smp_phase), 32'(prev_phase));
        end
        last_acc = req_valid && req_ready;
        chk("csb01", 32'(csb01), 32'(!(last_acc && !req_phase[7])));
        chk("csb11", 32'(csb11), 32'(!(last_acc && req_phase[7])));
        if (last_acc) chk("addr1", 32'(addr1), 32'(req_phase[6:0]));
        last_csb01 = csb01;
        last_csb11 = csb11;
        last_pop = smp_valid && smp_ready;
        if (last_pop) begin
            if (q.size() == 0) begin
                chk("pop_expected", 32'd0, 32'd1);
            end else begin
                ph = q.pop_front();
                last_pop_phase = smp_phase;
                chk("smp_phase", 32'(smp_phase), 32'(ph));
                chk("smp_data", 32'(smp_data), 32'(ref_sample(ph)));
            end
        end
        if (last_acc) q.push_back(req_phase);
        prev_stall = smp_valid && !smp_ready;
        prev_data  = smp_data;
        prev_phase = smp_phase;
        @(posedge clk);
        if (reset) run_m = 1'b1;
        #1;
    endtask

    // Checks applied the moment reset is asserted; model state is cleared.
    task automatic assert_reset();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_csb", {30'd0, csb01, csb11}, 32'd3);
        chk("rst_addr1", 32'(addr1), 32'd0);
        chk("rst_smp_valid", 32'(smp_valid), 32'd0);
        chk("rst_smp_data", 32'(smp_data), 32'd0);
        chk("rst_smp_phase", 32'(smp_phase), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        q.delete();
        run_m = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic drain(input string name);
        req_valid = 1'b0;
        smp_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        chk(name, 32'(q.size()), 32'd0);
    endtask

    typedef struct {
        logic [7:0]       phase;
        logic [OUT_W-1:0] exp_data;
        logic [1:0]       exp_csb;   // {csb01, csb11} during accept
    } vec_t;

    vec_t vecs [4];

    initial begin
        int ph;
        int cycles;
        int acc_cycles;
        int pops;
        int gaps;
        int first_pop;
        int prev_pop;
        bit got;
        real r;

        for (int i = 0; i < 256; i++) begin
            r = $sin(3.141592653589793 * i / 128.0) * 2147483647.0;
            tbl[i] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        end
        vecs[0] = '{8'd0,   8'h00, 2'b01};
        vecs[1] = '{8'd32,  8'h5B, 2'b01};
        vecs[2] = '{8'd64,  8'h7F, 2'b01};
        vecs[3] = '{8'd192, 8'h80, 2'b10};

        enable = 1'b1; req_valid = 1'b0; req_phase = 8'd0; smp_ready = 1'b1;
        dout01 = 32'd0; dout11 = 32'd0;
        prev_stall = 1'b0; run_m = 1'b0;
        assert_reset();
        cyc(); cyc();
        reset = 1'b1;
        cyc();

        // Table vectors: 2-cycle latency, bank selection, rounding/saturation
        foreach (vecs[k]) begin
            req_valid = 1'b1; req_phase = vecs[k].phase; smp_ready = 1'b1;
            cyc();
            chk("t1_accept", 32'(last_acc), 32'd1);
            chk("t1_csb", {30'd0, last_csb01, last_csb11}, 32'(vecs[k].exp_csb));
            req_valid = 1'b0;
            chk("t1_lat_n", 32'(smp_valid), 32'd0);
            cyc();
            chk("t1_lat_n1", 32'(smp_valid), 32'd1);
            chk("t1_data", 32'(smp_data), 32'(vecs[k].exp_data));
            chk("t1_phase", 32'(smp_phase), 32'(vecs[k].phase));
            cyc();
        end

        // Back-to-back stream of all phases
        ph = 0; cycles = 0; acc_cycles = 0; pops = 0; gaps = 0; first_pop = -1; prev_pop = -1;
        smp_ready = 1'b1;
        while ((ph < 256 || q.size() != 0) && cycles < 400) begin
            req_valid = (ph < 256);
            req_phase = 8'(ph);
            if (ph < 256) acc_cycles++;
            cyc();
            if (last_acc) ph++;
            if (last_pop) begin
                if (first_pop < 0) first_pop = cycles;
                else if (cycles != prev_pop + 1) gaps++;
                prev_pop = cycles;
                pops++;
            end
            cycles++;
        end
        chk("t2_accepts", 32'(ph), 32'd256);
        chk("t2_accept_cycles", 32'(acc_cycles), 32'd256);
        chk("t2_pops", 32'(pops), 32'd256);
        chk("t2_first_pop", 32'(first_pop), 32'd2);
        chk("t2_gaps", 32'(gaps), 32'd0);

        // Backpressure: exactly DEPTH accepts, then resume after first pop
        smp_ready = 1'b0; ph = 0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_phase = 8'(ph);
            cyc();
            if (last_acc) ph++;
        end
        chk("t3_accepts", 32'(ph), 32'(DEPTH));
        chk("t3_ready_low", 32'(req_ready), 32'd0);
        smp_ready = 1'b1; req_phase = 8'(ph);
        cyc();
        chk("t3_first_pop", 32'(last_pop), 32'd1);
        chk("t3_first_pop_phase", 32'(last_pop_phase), 32'd0);
        chk("t3_no_same_cycle_acc", 32'(last_acc), 32'd0);
        cyc();
        chk("t3_resume", 32'(last_acc), 32'd1);
        drain("t3_drain");

        // Enable drop after accepting phase 127
        req_valid = 1'b1; req_phase = 8'd127;
        cyc();
        chk("t4_accept", 32'(last_acc), 32'd1);
        enable = 1'b0; req_phase = 8'd128;
        cyc();
        chk("t4_csb_high", {30'd0, last_csb01, last_csb11}, 32'd3);
        chk("t4_no_accept", 32'(last_acc), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cyc();
            if (last_pop) got = 1'b1;
        end
        chk("t4_sample_arrived", 32'(got), 32'd1);
        chk("t4_sample_phase", 32'(last_pop_phase), 32'd127);
        chk("t4_busy_low", 32'(busy), 32'd0);
        chk("t4_ready_low", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        cyc();
        enable = 1'b1;

        // Reset with one read in flight and three FIFO entries
        smp_ready = 1'b0; ph = 10;
        for (int i = 0; i < 8 && ph < 14; i++) begin
            req_valid = 1'b1; req_phase = 8'(ph);
            cyc();
            if (last_acc) ph++;
        end
        chk("t5_loaded", 32'(ph), 32'd14);
        chk("t5_count", 32'(q.size()), 32'd4);
        req_valid = 1'b0;
        assert_reset();
        cyc(); cyc();
        reset = 1'b1; smp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t5_no_stale", 32'(smp_valid), 32'd0);
        end
        req_valid = 1'b1; req_phase = 8'd5;
        cyc();
        chk("t5_accept5", 32'(last_acc), 32'd1);
        req_valid = 1'b0;
        cyc();
        chk("t5_valid5", 32'(smp_valid), 32'd1);
        chk("t5_data5", 32'(smp_data), 32'h10);
        chk("t5_phase5", 32'(smp_phase), 32'd5);
        drain("t5_drain");

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 2000; i++) begin
            enable    = ($urandom_range(0, 15) != 0);
            req_valid = $urandom_range(0, 1) != 0;
            req_phase = 8'($urandom);
            smp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        enable = 1'b1;
        drain("t6_drain");
        cyc();
        chk("t6_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
